// File: rtl/encoder_8b10b_lanes.sv
`default_nettype none
// ============================================================================
// Module  : encoder_8b10b_lanes
// Multi-lane pipelined 8b/10b encoder; running disparity chained lane 0 -> LANES-1.
// Option  : define ENC8B10B_KCHECK_EN to flag illegal K codes on k_err_o.
// Rev     : 1.0  initial release
// ============================================================================
module encoder_8b10b_lanes #(
  parameter int LANES  = 2,
  parameter int REG_IN = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [8*LANES-1:0]    s_data_i,
  input  logic [LANES-1:0]      s_k_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [10*LANES-1:0]   m_data_o,
  output logic                  m_rd_o,
  output logic [LANES-1:0]      k_err_o
);

  // RD- form of the 6b code for each 5-bit value x = EDCBA
  function automatic logic [5:0] tab6(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;  5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;  5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;  5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;  5'd13: c = 6'b101100;  5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;  5'd17: c = 6'b100011;  5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;  5'd21: c = 6'b101010;  5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;  5'd25: c = 6'b100110;  5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;  5'd29: c = 6'b101110;  5'd30: c = 6'b011110;  default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // Returns {rd_out, abcdei, fghj}
  function automatic logic [10:0] enc_byte(input logic [7:0] b, input logic k, input logic rd);
    logic [4:0] x;
    logic [2:0] y;
    logic       is28, a7, rd6, rdo;
    logic [5:0] c6;
    logic [3:0] c4;
    x    = b[4:0];
    y    = b[7:5];
    is28 = k && (x == 5'd28);
    c6   = is28 ? 6'b001111 : tab6(x);
    if (rd && (($countones(c6) != 3) || (c6 == 6'b111000))) c6 = ~c6;
    rd6  = rd ^ ($countones(c6) != 3);
    // Alternate x.A7 avoids a run of five identical bits across the sub-block boundary
    a7   = k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20))
             || ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = 4'b1001;
      3'd2:    c4 = 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = 4'b1010;
      3'd6:    c4 = 4'b0110;
      default: c4 = a7 ? 4'b0111 : 4'b1110;
    endcase
    if (is28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) c4 = ~c4;
    if (rd6 && (is28 || ($countones(c4) != 2) || (c4 == 4'b1100))) c4 = ~c4;
    rdo  = rd6 ^ ($countones(c4) != 2);
    return {rdo, c6, c4};
  endfunction

  logic                  out_ready;
  logic                  src_valid;
  logic [8*LANES-1:0]    src_data;
  logic [LANES-1:0]      src_k;

  assign out_ready = ~m_valid_o | m_ready_i;

  generate
    if (REG_IN != 0) begin : g_reg_in
      logic               in_valid_q;
      logic [8*LANES-1:0] in_data_q;
      logic [LANES-1:0]   in_k_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          in_valid_q <= 1'b0;
          in_data_q  <= '0;
          in_k_q     <= '0;
        end else if (s_ready_o) begin
          in_valid_q <= s_valid_i;
          if (s_valid_i) begin
            in_data_q <= s_data_i;
            in_k_q    <= s_k_i;
          end
        end
      end

      assign s_ready_o = ~in_valid_q | out_ready;
      assign src_valid = in_valid_q;
      assign src_data  = in_data_q;
      assign src_k     = in_k_q;
    end else begin : g_no_reg_in
      assign s_ready_o = out_ready;
      assign src_valid = s_valid_i;
      assign src_data  = s_data_i;
      assign src_k     = s_k_i;
    end
  endgenerate

  logic                  rd_q, rd_d;
  logic                  m_valid_q;
  logic [10*LANES-1:0]   m_data_q, m_data_d;

  always_comb begin
    logic [10:0] r;
    r        = '0;
    rd_d     = rd_q;
    m_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      r = enc_byte(src_data[8*i +: 8], src_k[i], rd_d);
      m_data_d[10*i +: 10] = r[9:0];
      rd_d = r[10];
    end
  end

  // RD advances only when a word actually enters the output register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      rd_q      <= 1'b0;
    end else if (out_ready) begin
      m_valid_q <= src_valid;
      if (src_valid) begin
        m_data_q <= m_data_d;
        rd_q     <= rd_d;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_rd_o    = rd_q;

`ifdef ENC8B10B_KCHECK_EN
  function automatic logic k_bad(input logic [7:0] b, input logic k);
    return k && !((b[4:0] == 5'd28) || (b == 8'hF7) || (b == 8'hFB) ||
                  (b == 8'hFD) || (b == 8'hFE));
  endfunction

  logic [LANES-1:0] k_err_q, k_err_d;

  always_comb begin
    k_err_d = '0;
    for (int i = 0; i < LANES; i++) k_err_d[i] = k_bad(src_data[8*i +: 8], src_k[i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     k_err_q <= '0;
    else if (out_ready && src_valid) k_err_q <= k_err_d;
  end

  assign k_err_o = k_err_q;
`else
  assign k_err_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_encoder_8b10b_lanes.sv
`default_nettype none
// Bench for encoder_8b10b_lanes: one-lane unregistered instance and two-lane
// registered-input instance driven with hand-computed 8b/10b vectors.
module tb_encoder_8b10b_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        s_valid1, s_ready1, m_valid1, m_ready1, m_rd1;
  logic [7:0]  s_data1;
  logic [0:0]  s_k1, k_err1;
  logic [9:0]  m_data1;

  logic        s_valid2, s_ready2, m_valid2, m_ready2, m_rd2;
  logic [15:0] s_data2;
  logic [1:0]  s_k2, k_err2;
  logic [19:0] m_data2;

  encoder_8b10b_lanes #(.LANES(1), .REG_IN(0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid1), .s_ready_o(s_ready1), .s_data_i(s_data1), .s_k_i(s_k1),
    .m_valid_o(m_valid1), .m_ready_i(m_ready1), .m_data_o(m_data1), .m_rd_o(m_rd1),
    .k_err_o(k_err1)
  );

  encoder_8b10b_lanes #(.LANES(2), .REG_IN(1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_valid_i(s_valid2), .s_ready_o(s_ready2), .s_data_i(s_data2), .s_k_i(s_k2),
    .m_valid_o(m_valid2), .m_ready_i(m_ready2), .m_data_o(m_data2), .m_rd_o(m_rd2),
    .k_err_o(k_err2)
  );

  typedef struct {
    logic [7:0] b;
    logic       k;
    logic [9:0] code;
    logic       rd;
    logic       kerr;
  } vec_t;

  vec_t vt[17];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] held;
    logic        held_rd, was_stalled, saw_sready_low;
    int          idx, outidx;

    // Serial stream from RD-; each entry encodes from the RD left by the previous one
    vt[0]  = '{8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0}; // D0.0
    vt[1]  = '{8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0}; // K28.5 RD-
    vt[2]  = '{8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0}; // K28.5 RD+
    vt[3]  = '{8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0}; // D17.7 A7
    vt[4]  = '{8'hB5, 1'b0, 10'b1010101010, 1'b1, 1'b0}; // D21.5
    vt[5]  = '{8'h03, 1'b0, 10'b1100010100, 1'b0, 1'b0}; // D3.0 RD+
    vt[6]  = '{8'hEB, 1'b0, 10'b1101001110, 1'b1, 1'b0}; // D11.7 RD- (P7)
    vt[7]  = '{8'hEB, 1'b0, 10'b1101001000, 1'b0, 1'b0}; // D11.7 RD+ (A7)
    vt[8]  = '{8'h07, 1'b0, 10'b1110001011, 1'b1, 1'b0}; // D7.0 RD-
    vt[9]  = '{8'h07, 1'b0, 10'b0001110100, 1'b0, 1'b0}; // D7.0 RD+
    vt[10] = '{8'hFF, 1'b0, 10'b1010110001, 1'b0, 1'b0}; // D31.7
    vt[11] = '{8'hFC, 1'b1, 10'b0011111000, 1'b0, 1'b0}; // K28.7
    vt[12] = '{8'hF7, 1'b1, 10'b1110101000, 1'b0, 1'b0}; // K23.7
    vt[13] = '{8'h78, 1'b0, 10'b1100110011, 1'b1, 1'b0}; // D24.3
    vt[14] = '{8'hF4, 1'b0, 10'b0010110001, 1'b0, 1'b0}; // D20.7 RD+
    vt[15] = '{8'hF4, 1'b0, 10'b0010110111, 1'b1, 1'b0}; // D20.7 RD- (A7)
    vt[16] = '{8'h00, 1'b1, 10'b0110001011, 1'b1, 1'b1}; // K with non-K byte

    rst_n = 1'b0;
    s_valid1 = 1'b0; s_data1 = '0; s_k1 = '0; m_ready1 = 1'b1;
    s_valid2 = 1'b0; s_data2 = '0; s_k2 = '0; m_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset m_valid1", m_valid1, 0);
    check("reset m_data1",  m_data1,  0);
    check("reset m_rd1",    m_rd1,    0);
    check("reset m_valid2", m_valid2, 0);
    check("reset m_data2",  m_data2,  0);
    check("reset k_err2",   k_err2,   0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_valid1 = 1'b1; s_data1 = vt[i].b; s_k1 = vt[i].k;
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", i), m_valid1, 1);
      check($sformatf("vec%0d code", i),  m_data1,  vt[i].code);
      check($sformatf("vec%0d rd", i),    m_rd1,    vt[i].rd);
`ifdef ENC8B10B_KCHECK_EN
      check($sformatf("vec%0d kerr", i),  k_err1,   vt[i].kerr);
`endif
    end
    @(negedge clk) s_valid1 = 1'b0;
    @(posedge clk); #1;
    check("idle m_valid1", m_valid1, 0);
    check("idle holds rd", m_rd1, 1);

    // Async reset mid-cycle with RD+ held and a word waiting at the input
    @(negedge clk);
    s_valid1 = 1'b1; s_data1 = 8'h03; s_k1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst m_valid1", m_valid1, 0);
    check("midrst m_data1",  m_data1,  0);
    check("midrst m_rd1",    m_rd1,    0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset D3.0 code", m_data1, 10'b1100011011);
    check("post-reset D3.0 rd",   m_rd1,   1);
    @(negedge clk) s_valid1 = 1'b0;

    // Two-lane latency and intra-word RD chaining
    @(negedge clk);
    s_valid2 = 1'b1; s_data2 = 16'hBCBC; s_k2 = 2'b11;
    @(posedge clk); #1;
    check("lat2 not yet valid", m_valid2, 0);
    @(negedge clk) s_valid2 = 1'b0;
    @(posedge clk); #1;
    check("K28.5x2 valid", m_valid2, 1);
    check("K28.5x2 code",  m_data2,  {10'b1100000101, 10'b0011111010});
    check("K28.5x2 rd",    m_rd2,    0);
    @(posedge clk); #1;
    check("K28.5x2 drained", m_valid2, 0);

    // Streaming with a 5-cycle downstream stall; expected words pair up the serial table
    idx = 0; outidx = 0; was_stalled = 1'b0; saw_sready_low = 1'b0;
    held = '0; held_rd = 1'b0;
    for (int c = 0; c < 80 && outidx < 8; c++) begin
      logic will_acc;
      @(negedge clk);
      m_ready2 = !(c >= 3 && c < 8);
      s_valid2 = (idx < 8);
      if (idx < 8) begin
        s_data2 = {vt[2*idx+1].b, vt[2*idx].b};
        s_k2    = {vt[2*idx+1].k, vt[2*idx].k};
      end
      #1;
      will_acc = s_valid2 && s_ready2;
      if (!m_ready2 && !s_ready2) saw_sready_low = 1'b1;
      if (m_valid2 && !m_ready2) begin
        if (was_stalled) begin
          check($sformatf("stall c%0d data stable", c), m_data2, held);
          check($sformatf("stall c%0d rd stable", c),   m_rd2,   held_rd);
        end
        held = m_data2; held_rd = m_rd2; was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (m_valid2 && m_ready2) begin
        check($sformatf("stream w%0d code", outidx), m_data2,
              {vt[2*outidx+1].code, vt[2*outidx].code});
        check($sformatf("stream w%0d rd", outidx), m_rd2, vt[2*outidx+1].rd);
        outidx++;
      end
      @(posedge clk);
      if (will_acc) idx++;
    end
    check("stream all words out", outidx, 8);
    check("s_ready dropped under stall", saw_sready_low, 1);
    @(negedge clk) begin s_valid2 = 1'b0; m_ready2 = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    check("no duplicate after stream", m_valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
